wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4, SHALL set how many cycles a buffered long-latency result may be denied the write port before the pipeline is stalled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 pipe_we  input  1  pipeline write-back stage requests a register write this cycle.
REQ-005 pipe_wp  input  4  pipeline destination register (r15 already resolved for calls).
REQ-006 pipe_wd  input  32  pipeline write data (ALU, load or pc+1 result).
REQ-007 ll_valid  input  1  long-latency unit (mul/div) offers a result.
REQ-008 ll_rd  input  4  long-latency destination register.
REQ-009 ll_data  input  32  long-latency result.
REQ-010 ll_ready  output  1  arbiter can accept an LL result this cycle.
REQ-011 stall_pipe  output  1  pipeline SHALL hold its write-back inputs unchanged while high.
REQ-012 rf_we  output  1  register-file write enable, registered.
REQ-013 rf_wp  output  4  register-file write port address, registered.
REQ-014 rf_wd  output  32  register-file write data, registered.
REQ-015 ll_drop  output  1  one-cycle pulse when a buffered LL entry is discarded without a write.

Function
REQ-016 The block SHALL hold a 2-entry FIFO of {live, rd, data} for LL results; ll_ready = (count < 2), computed from the current count only; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-017 An LL result SHALL be enqueued with live=1 on a rising edge where ll_valid && ll_ready; ll_valid without ll_ready SHALL be ignored, and the LL unit holds its result.
REQ-018 The state machine SHALL have states NORMAL and FORCE.
REQ-019 In NORMAL, grant priority SHALL be: pipe_we, then a live head entry, then none.
REQ-020 In FORCE, a live head entry SHALL be granted, and pipe inputs SHALL be ignored; stall_pipe = 1 exactly while in FORCE.
REQ-021 A grant SHALL produce rf_we=1 with that source's rd/data on the next edge (latency 1 cycle); no grant SHALL produce rf_we=0, and rf_wp/rf_wd SHALL hold their previous values.
REQ-022 Granting the head entry SHALL pop it.
REQ-023 A non-live head entry SHALL be popped without a write in any cycle in which the port is not given to it, including cycles with pipe_we=1, and ll_drop SHALL pulse on that edge.
REQ-024 A pipe write grant SHALL clear live on every FIFO entry whose rd equals pipe_wp, because the later in-order write wins.
REQ-025 An entry enqueued on the same edge as a pipe write SHALL NOT be squashed by that write.
REQ-026 A 4-bit wait counter SHALL increment each NORMAL cycle in which a live head exists but the pipe wins, and SHALL clear on head pop or when the FIFO is empty.
REQ-027 When the wait counter equals MAX_WAIT at an edge, the state SHALL go NORMAL->FORCE.
REQ-028 FORCE SHALL last exactly one cycle, then return to NORMAL with the counter cleared.
REQ-029 If the head is squashed while the counter is nonzero, the counter SHALL clear; FORCE entered with a non-live head SHALL drop it, pulse ll_drop, and still return to NORMAL.
REQ-030 Enqueue and pop on the same edge SHALL leave count unchanged and preserve entry order; FIFO pointers SHALL wrap modulo 2.

Reset
REQ-031 While rst_n=0, all of the following SHALL hold immediately, without waiting for clk: state=NORMAL, FIFO empty, counter=0, rf_we=0, rf_wp=0, rf_wd=0, stall_pipe=0, ll_drop=0, ll_ready=1.
REQ-032 Reset asserted mid-operation SHALL discard buffered LL entries with no write and no ll_drop pulse.
REQ-033 The first grant after rst_n rises SHALL occur no earlier than the first rising edge following deassertion.

Verification
REQ-034 Idle pipe; ll_valid with rd=3, data=0xDEADBEEF -> the next edge enqueues it, the following edge gives rf_we=1, rf_wp=3, rf_wd=0xDEADBEEF, and ll_ready stays 1.
REQ-035 pipe_we held at 1 (rd=5), one LL entry rd=7, MAX_WAIT=4 -> 4 pipe writes, then stall_pipe=1 for 1 cycle, then an rf write of r7, then pipe writes resume.
REQ-036 LL entry rd=2 buffered, then a pipe write to r2 -> the r2 pipe value is written, the LL entry is dropped with a single ll_drop pulse, and r2 is never overwritten by LL data.
REQ-037 Pipe busy, 3 LL results offered back-to-back -> 2 accepted, ll_ready=0 while full, the third accepted only after a pop, and rf writes occur in order.
REQ-038 rst_n pulsed low with 2 entries buffered and in FORCE -> all outputs go to reset values asynchronously, no write or drop occurs, and the FIFO is empty after reset.
REQ-039 The same edge has a pipe write to r9 and enqueue of LL rd=9 -> the new entry stays live and is written after the pipe write.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port arbitration bus.
// Groups the pipeline write-back request, the long-latency (mul/div) result
// handshake and the arbitrated register-file write port.
//   master : pipeline / LL unit / register file side (drives requests)
//   slave  : the arbiter (drives ll_ready, stall_pipe, rf_*, ll_drop)
interface wb_port_arbiter_if;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 32;

    logic              pipe_we;
    logic [REG_W-1:0]  pipe_wp;
    logic [DATA_W-1:0] pipe_wd;
    logic              ll_valid;
    logic [REG_W-1:0]  ll_rd;
    logic [DATA_W-1:0] ll_data;
    logic              ll_ready;
    logic              stall_pipe;
    logic              rf_we;
    logic [REG_W-1:0]  rf_wp;
    logic [DATA_W-1:0] rf_wd;
    logic              ll_drop;

    modport master (
        output pipe_we, pipe_wp, pipe_wd, ll_valid, ll_rd, ll_data,
        input  ll_ready, stall_pipe, rf_we, rf_wp, rf_wd, ll_drop
    );

    modport slave (
        input  pipe_we, pipe_wp, pipe_wd, ll_valid, ll_rd, ll_data,
        output ll_ready, stall_pipe, rf_we, rf_wp, rf_wd, ll_drop
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared between the in-order pipeline
// write-back stage and a long-latency unit. LL results are buffered in a
// 2-entry FIFO; the pipeline has priority, but a live LL head that has been
// denied MAX_WAIT times forces a one-cycle pipeline stall so it can drain.
// A pipeline write to a register squashes older buffered LL results for it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_port_arbiter_if.slave (pipe_*, ll_*, rf_*, stall_pipe, ll_drop)
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } ll_entry_t;

    state_t              state_q, state_d;
    ll_entry_t           fifo_q [DEPTH];
    ll_entry_t           fifo_d [DEPTH];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                rf_we_q, rf_we_d;
    logic [REG_W-1:0]    rf_wp_q, rf_wp_d;
    logic [DATA_W-1:0]   rf_wd_q, rf_wd_d;
    logic                ll_drop_q, ll_drop_d;
    logic                stall_q, stall_d;
    logic                ll_ready_q, ll_ready_d;

    ll_entry_t           head;
    logic                head_vld;
    logic                head_live;
    logic                enq;
    logic                pop;
    logic                pipe_grant;

    // Arbitration, FIFO bookkeeping and next-state logic
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        wait_d     = wait_q;
        rf_we_d    = 1'b0;
        rf_wp_d    = rf_wp_q;
        rf_wd_d    = rf_wd_q;
        ll_drop_d  = 1'b0;
        pop        = 1'b0;
        pipe_grant = 1'b0;

        head      = fifo_q[rd_ptr_q];
        head_vld  = (count_q != '0);
        head_live = head_vld && head.live;
        // Readiness comes from the registered count, so a same-cycle pop
        // never opens a full FIFO.
        enq       = bus.ll_valid && ll_ready_q;

        case (state_q)
            NORMAL: begin
                wait_d = '0;
                if (bus.pipe_we) begin
                    pipe_grant = 1'b1;
                    rf_we_d    = 1'b1;
                    rf_wp_d    = bus.pipe_wp;
                    rf_wd_d    = bus.pipe_wd;
                    if (head_vld && !head.live) begin
                        pop       = 1'b1;
                        ll_drop_d = 1'b1;
                    end else if (head_live && (head.rd != bus.pipe_wp)) begin
                        // A head squashed by this write leaves the counter cleared
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else if (head_live) begin
                    pop     = 1'b1;
                    rf_we_d = 1'b1;
                    rf_wp_d = head.rd;
                    rf_wd_d = head.data;
                end else if (head_vld) begin
                    pop       = 1'b1;
                    ll_drop_d = 1'b1;
                end
                if (wait_d == WAIT_W'(MAX_WAIT)) begin
                    state_d = FORCE;
                end
            end
            FORCE: begin
                if (head_live) begin
                    pop     = 1'b1;
                    rf_we_d = 1'b1;
                    rf_wp_d = head.rd;
                    rf_wd_d = head.data;
                end else if (head_vld) begin
                    pop       = 1'b1;
                    ll_drop_d = 1'b1;
                end
                wait_d  = '0;
                state_d = NORMAL;
            end
            default: begin
                wait_d  = '0;
                state_d = NORMAL;
            end
        endcase

        // Later in-order pipe write wins over older buffered results
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
            if (pipe_grant && (fifo_q[i].rd == bus.pipe_wp)) begin
                fifo_d[i].live = 1'b0;
            end
        end
        // Enqueue after the squash so a same-edge entry stays live
        if (enq) begin
            fifo_d[wr_ptr_q].live = 1'b1;
            fifo_d[wr_ptr_q].rd   = bus.ll_rd;
            fifo_d[wr_ptr_q].data = bus.ll_data;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        count_d    = count_q + CNT_W'(enq) - CNT_W'(pop);
        ll_ready_d = (count_d < CNT_W'(DEPTH));
        stall_d    = (state_d == FORCE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NORMAL;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            wait_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_wp_q    <= '0;
            rf_wd_q    <= '0;
            ll_drop_q  <= 1'b0;
            stall_q    <= 1'b0;
            ll_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            rf_we_q    <= rf_we_d;
            rf_wp_q    <= rf_wp_d;
            rf_wd_q    <= rf_wd_d;
            ll_drop_q  <= ll_drop_d;
            stall_q    <= stall_d;
            ll_ready_q <= ll_ready_d;
        end
    end

    assign bus.ll_ready   = ll_ready_q;
    assign bus.stall_pipe = stall_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wp      = rf_wp_q;
    assign bus.rf_wd      = rf_wd_q;
    assign bus.ll_drop    = ll_drop_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (MAX_WAIT = 4).
module tb_wb_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, leave time for outputs to settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_we  = 1'b0;
        bus.pipe_wp  = 4'd0;
        bus.pipe_wd  = 32'd0;
        bus.ll_valid = 1'b0;
        bus.ll_rd    = 4'd0;
        bus.ll_data  = 32'd0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".rf_we"},    32'(bus.rf_we),      32'd0);
        check({tag, ".rf_wp"},    32'(bus.rf_wp),      32'd0);
        check({tag, ".rf_wd"},    bus.rf_wd,           32'd0);
        check({tag, ".stall"},    32'(bus.stall_pipe), 32'd0);
        check({tag, ".drop"},     32'(bus.ll_drop),    32'd0);
        check({tag, ".ll_ready"}, 32'(bus.ll_ready),   32'd1);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst.rf_we", 32'(bus.rf_we), 32'd0);

        // Idle pipe, single LL result
        bus.ll_valid = 1'b1; bus.ll_rd = 4'd3; bus.ll_data = 32'hDEAD_BEEF;
        tick();
        check("ll1.enq.rf_we", 32'(bus.rf_we), 32'd0);
        check("ll1.enq.ready", 32'(bus.ll_ready), 32'd1);
        idle();
        tick();
        check("ll1.rf_we",  32'(bus.rf_we), 32'd1);
        check("ll1.rf_wp",  32'(bus.rf_wp), 32'd3);
        check("ll1.rf_wd",  bus.rf_wd, 32'hDEAD_BEEF);
        check("ll1.ready",  32'(bus.ll_ready), 32'd1);
        tick();
        check("ll1.idle.rf_we", 32'(bus.rf_we), 32'd0);
        check("ll1.hold.rf_wp", 32'(bus.rf_wp), 32'd3);
        check("ll1.hold.rf_wd", bus.rf_wd, 32'hDEAD_BEEF);

        // Starvation: pipe holds r5, LL r7 forced through after 4 denials
        bus.pipe_we = 1'b1; bus.pipe_wp = 4'd5; bus.pipe_wd = 32'h0000_0055;
        bus.ll_valid = 1'b1; bus.ll_rd = 4'd7; bus.ll_data = 32'h0000_0077;
        tick();
        bus.ll_valid = 1'b0;
        check("starve.e1.rf_wp", 32'(bus.rf_wp), 32'd5);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("starve.e%0d.rf_wp", k), 32'(bus.rf_wp), 32'd5);
            check($sformatf("starve.e%0d.stall", k), 32'(bus.stall_pipe), 32'd0);
        end
        tick();
        check("starve.e5.rf_wp", 32'(bus.rf_wp), 32'd5);
        check("starve.e5.stall", 32'(bus.stall_pipe), 32'd1);
        tick();
        check("starve.e6.stall", 32'(bus.stall_pipe), 32'd0);
        check("starve.e6.rf_we", 32'(bus.rf_we), 32'd1);
        check("starve.e6.rf_wp", 32'(bus.rf_wp), 32'd7);
        check("starve.e6.rf_wd", bus.rf_wd, 32'h0000_0077);
        tick();
        check("starve.e7.rf_wp", 32'(bus.rf_wp), 32'd5);
        check("starve.e7.stall", 32'(bus.stall_pipe), 32'd0);
        idle();
        tick();
        check("starve.idle.rf_we", 32'(bus.rf_we), 32'd0);

        // Squash: buffered LL r2 overtaken by a pipe write to r2
        bus.pipe_we = 1'b1; bus.pipe_wp = 4'd4; bus.pipe_wd = 32'h0000_0044;
        bus.ll_valid = 1'b1; bus.ll_rd = 4'd2; bus.ll_data = 32'h0000_0BAD;
        tick();
        bus.ll_valid = 1'b0;
        bus.pipe_wp = 4'd2; bus.pipe_wd = 32'h0000_0022;
        tick();
        check("squash.pipe.rf_wp", 32'(bus.rf_wp), 32'd2);
        check("squash.pipe.rf_wd", bus.rf_wd, 32'h0000_0022);
        check("squash.pipe.drop",  32'(bus.ll_drop), 32'd0);
        idle();
        tick();
        check("squash.drop",       32'(bus.ll_drop), 32'd1);
        check("squash.drop.rf_we", 32'(bus.rf_we), 32'd0);
        tick();
        check("squash.after.drop",  32'(bus.ll_drop), 32'd0);
        check("squash.after.rf_we", 32'(bus.rf_we), 32'd0);
        check("squash.after.rf_wd", bus.rf_wd, 32'h0000_0022);

        // Back-pressure: three LL results while the pipe is busy
        bus.pipe_we = 1'b1; bus.pipe_wp = 4'd6; bus.pipe_wd = 32'h0000_0066;
        bus.ll_valid = 1'b1; bus.ll_rd = 4'd10; bus.ll_data = 32'h0000_00A0;
        tick();
        check("bp.e1.ready", 32'(bus.ll_ready), 32'd1);
        bus.ll_rd = 4'd11; bus.ll_data = 32'h0000_00A1;
        tick();
        check("bp.e2.ready", 32'(bus.ll_ready), 32'd0);
        bus.ll_rd = 4'd12; bus.ll_data = 32'h0000_00A2;
        tick();
        check("bp.e3.ready", 32'(bus.ll_ready), 32'd0);
        tick();
        tick();
        check("bp.e5.stall", 32'(bus.stall_pipe), 32'd1);
        check("bp.e5.ready", 32'(bus.ll_ready), 32'd0);
        tick();
        check("bp.e6.rf_wp", 32'(bus.rf_wp), 32'd10);
        check("bp.e6.rf_wd", bus.rf_wd, 32'h0000_00A0);
        check("bp.e6.ready", 32'(bus.ll_ready), 32'd1);
        tick();
        check("bp.e7.rf_wp", 32'(bus.rf_wp), 32'd6);
        check("bp.e7.ready", 32'(bus.ll_ready), 32'd0);
        idle();
        tick();
        check("bp.e8.rf_wp", 32'(bus.rf_wp), 32'd11);
        check("bp.e8.rf_wd", bus.rf_wd, 32'h0000_00A1);
        tick();
        check("bp.e9.rf_wp", 32'(bus.rf_wp), 32'd12);
        check("bp.e9.rf_wd", bus.rf_wd, 32'h0000_00A2);
        check("bp.e9.ready", 32'(bus.ll_ready), 32'd1);
        tick();
        check("bp.e10.rf_we", 32'(bus.rf_we), 32'd0);

        // Same-edge pipe write r9 and enqueue of LL r9
        bus.pipe_we = 1'b1; bus.pipe_wp = 4'd9; bus.pipe_wd = 32'h0000_0099;
        bus.ll_valid = 1'b1; bus.ll_rd = 4'd9; bus.ll_data = 32'h0000_009E;
        tick();
        check("same.pipe.rf_wd", bus.rf_wd, 32'h0000_0099);
        idle();
        tick();
        check("same.ll.rf_we", 32'(bus.rf_we), 32'd1);
        check("same.ll.rf_wp", 32'(bus.rf_wp), 32'd9);
        check("same.ll.rf_wd", bus.rf_wd, 32'h0000_009E);
        check("same.ll.drop",  32'(bus.ll_drop), 32'd0);
        tick();

        // Reset while full and in FORCE
        bus.pipe_we = 1'b1; bus.pipe_wp = 4'd6; bus.pipe_wd = 32'h0000_0066;
        bus.ll_valid = 1'b1; bus.ll_rd = 4'd13; bus.ll_data = 32'h0000_00D0;
        tick();
        bus.ll_rd = 4'd14; bus.ll_data = 32'h0000_00D1;
        tick();
        bus.ll_valid = 1'b0;
        tick();
        tick();
        tick();
        check("rstmid.pre.stall", 32'(bus.stall_pipe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset("rstmid_async");
        idle();
        tick();
        check("rstmid.held.rf_we", 32'(bus.rf_we), 32'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstmid.post%0d.rf_we", k), 32'(bus.rf_we), 32'd0);
            check($sformatf("rstmid.post%0d.drop", k),  32'(bus.ll_drop), 32'd0);
            check($sformatf("rstmid.post%0d.rf_wp", k), 32'(bus.rf_wp), 32'd0);
            check($sformatf("rstmid.post%0d.ready", k), 32'(bus.ll_ready), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
